// File: rtl/bin2bcd_seq_if.sv
// Start/ready/done_tick handshake bundle between a binary producer and bin2bcd_seq.
// The blank mask is carried only when BLANK_EN is defined.
interface bin2bcd_seq_if #(
    parameter int N = 20,
    parameter int D = 7
);
    logic           start;
    logic [N-1:0]   bin_in;
    logic           ready;
    logic           done_tick;
    logic [4*D-1:0] bcd_out;
`ifdef BLANK_EN
    logic [D-1:0]   blank;

    modport master (output start, bin_in, input ready, done_tick, bcd_out, blank);
    modport slave  (input start, bin_in, output ready, done_tick, bcd_out, blank);
`else
    modport master (output start, bin_in, input ready, done_tick, bcd_out);
    modport slave  (input start, bin_in, output ready, done_tick, bcd_out);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BLANK_EN adds a registered leading-zero mask output.
module bin2bcd_seq #(
    parameter int N = 20,
    parameter int D = 7
) (
    input  logic         clk,
    input  logic         rst,
    bin2bcd_seq_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [4*D-1:0] work_q, work_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4*D-1:0] bcd_q, bcd_d;
    logic           ready;
    logic           done_tick;

    logic [4*D-1:0] work_adj;
    logic [4*D-1:0] work_sh;
    logic [N-1:0]   shift_sh;

    // Add-3 correction is per digit; no carry ripples between digits.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_adj
            assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5)
                                       ? work_q[4*gi +: 4] + 4'd3
                                       : work_q[4*gi +: 4];
        end
    endgenerate

    // The MSB leaving the top digit is dropped, giving value mod 10^D.
    assign work_sh  = {work_adj[4*D-2:0], shift_q[N-1]};
    assign shift_sh = {shift_q[N-2:0], 1'b0};

`ifdef BLANK_EN
    logic [D-1:0] blank_q, blank_d;
    logic [D-1:0] blank_new;

    assign blank_new[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < D; gi++) begin : g_blank
            assign blank_new[gi] = (work_sh[4*D-1:4*gi] == '0);
        end
    endgenerate
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
`ifdef BLANK_EN
        blank_d   = blank_q;
`endif
        ready     = 1'b0;
        done_tick = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.start) begin
                    shift_d = bus.bin_in;
                    work_d  = '0;
                    cnt_d   = CW'(N);
                    state_d = S_OP;
                end
            end
            S_OP: begin
                shift_d = shift_sh;
                work_d  = work_sh;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = work_sh;
`ifdef BLANK_EN
                    blank_d = blank_new;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_tick = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
`ifdef BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
`ifdef BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign bus.ready     = ready;
    assign bus.done_tick = done_tick;
    assign bus.bcd_out   = bcd_q;
`ifdef BLANK_EN
    assign bus.blank     = blank_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, corner sequences and random values
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
    localparam int N = 20;
    localparam int D = 7;

    logic clk = 1'b0;
    logic rst;

    bin2bcd_seq_if #(.N(N), .D(D)) ifc ();
    bin2bcd_seq #(.N(N), .D(D)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned    bin;
        logic [4*D-1:0] bcd;
        logic [D-1:0]   blank;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of value mod 10^D by plain division.
    function automatic logic [4*D-1:0] model_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned vv;
        r  = '0;
        vv = v % 10_000_000;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(vv % 10);
            vv = vv / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] model_blank(input int unsigned v);
        logic [D-1:0] b;
        int unsigned vm;
        int unsigned p;
        b  = '0;
        vm = v % 10_000_000;
        p  = 1;
        for (int i = 1; i < D; i++) begin
            p = p * 10;
            b[i] = (vm < p);
        end
        return b;
    endfunction

    function automatic int unsigned fib(input int n);
        int unsigned a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // One full conversion: wait for ready, accept, then check latency, result and handshake.
    task automatic run_conv(input int unsigned value, input logic [4*D-1:0] exp_bcd,
                            input logic [D-1:0] exp_blank);
        int g;
        int e;
        g = 0;
        @(negedge clk);
        while (!ifc.ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("ready_timeout", 0, 1);
        ifc.start  = 1'b1;
        ifc.bin_in = N'(value);
        @(posedge clk);
        #1;
        ifc.start  = 1'b0;
        ifc.bin_in = N'($urandom);
        check("ready_low_in_op", ifc.ready, 0);
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!ifc.done_tick && e < 60);
        check("done_latency_edges", e, N);
        check("bcd_out", ifc.bcd_out, exp_bcd);
`ifdef BLANK_EN
        check("blank", ifc.blank, exp_blank);
`else
        if (exp_blank === 'x) $display("unexpected blank expectation");
`endif
        check("ready_low_in_done", ifc.ready, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", ifc.done_tick, 0);
        check("ready_back", ifc.ready, 1);
        $display("conv bin=%0d bcd_out=%07h latency=%0d", value, ifc.bcd_out, e);
    endtask

    vec_t table_v[5];

    initial begin
        int unsigned r;
        int dones;
        table_v[0] = '{bin: 0,       bcd: 28'h0000000, blank: 7'b1111110};
        table_v[1] = '{bin: 6765,    bcd: 28'h0006765, blank: 7'b1110000};
        table_v[2] = '{bin: 1048575, bcd: 28'h1048575, blank: 7'b0000000};
        table_v[3] = '{bin: 599999,  bcd: 28'h0599999, blank: 7'b1000000};
        table_v[4] = '{bin: 10,      bcd: 28'h0000010, blank: 7'b1111100};

        rst        = 1'b1;
        ifc.start  = 1'b0;
        ifc.bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", ifc.ready, 1);
        check("reset_done", ifc.done_tick, 0);
        check("reset_bcd", ifc.bcd_out, 0);
`ifdef BLANK_EN
        check("reset_blank", ifc.blank, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_conv(table_v[i].bin, table_v[i].bcd, table_v[i].blank);

        // Result holds across idle.
        repeat (7) @(posedge clk);
        #1;
        check("bcd_hold_idle", ifc.bcd_out, 28'h0000010);

        // Start during op is ignored: one done_tick, first value only.
        @(negedge clk);
        ifc.start  = 1'b1;
        ifc.bin_in = N'(9);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ifc.start  = 1'b1;
        ifc.bin_in = N'(500);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (ifc.done_tick) dones++;
        end
        check("busy_start_done_count", dones, 1);
        check("busy_start_bcd", ifc.bcd_out, 28'h0000009);
        $display("conv bin=9 with ignored start bin=500 dones=%0d bcd_out=%07h", dones, ifc.bcd_out);

        // Asynchronous reset mid-op aborts the conversion.
        @(negedge clk);
        ifc.start  = 1'b1;
        ifc.bin_in = N'(12345);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ready", ifc.ready, 1);
        check("abort_done", ifc.done_tick, 0);
        check("abort_bcd", ifc.bcd_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ifc.done_tick) dones++;
        end
        check("abort_no_done", dones, 0);
        $display("abort bin=12345 dones=%0d bcd_out=%07h", dones, ifc.bcd_out);
        run_conv(42, 28'h0000042, 7'b1111100);

        // Chained after a behavioural Fibonacci generator, fib(10).
        run_conv(fib(10), 28'h0000055, 7'b1111100);

        // Random values against the decimal model.
        for (int k = 0; k < 20; k++) begin
            r = $urandom_range(0, (1 << N) - 1);
            run_conv(r, model_bcd(r), model_blank(r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
